// File: rtl/halo_receiver_pkg.sv
// halo_receiver_pkg: shared entry type and state encoding for the halo receiver
// Holds the buffered neighbor entry {value, row, column} and the receive-window states.
// Coordinates are stored at HALO_CW_MAX bits so one type serves any TILE_SIZE up to 65536.
package halo_receiver_pkg;
  localparam int HALO_CW_MAX = 16;
  typedef enum logic [1:0] {IDLE, RECEIVE, DRAIN, DONE} halo_state_t;
  typedef struct packed {
    logic [7:0] value;
    logic [HALO_CW_MAX-1:0] row;
    logic [HALO_CW_MAX-1:0] column;
  } halo_entry_t;
endpackage

// File: rtl/halo_receiver_if.sv
// halo_receiver_if: neighbor link inputs, per-link clear-to-send and tile buffer write port
// master: neighbor/buffer side (drives link entries, observes cts and buffer writes)
// slave : halo_receiver (consumes link entries, drives cts and buffer writes)
interface halo_receiver_if #(
  parameter int TILE_SIZE = 128,
  parameter int NEIGHBOR_COUNT = 8
);
  localparam int CW = $clog2(TILE_SIZE);
  logic [7:0] neighbor_input_value [NEIGHBOR_COUNT];
  logic [CW-1:0] neighbor_input_row [NEIGHBOR_COUNT];
  logic [CW-1:0] neighbor_input_column [NEIGHBOR_COUNT];
  logic [NEIGHBOR_COUNT-1:0] neighbor_input_write_enable;
  logic [NEIGHBOR_COUNT-1:0] neighbor_exchange_done;
  logic [NEIGHBOR_COUNT-1:0] neighbor_cts;
  logic [CW-1:0] buffer_row_write;
  logic [CW-1:0] buffer_column_write;
  logic [7:0] buffer_data_write;
  logic buffer_write_enable;
  modport master (
    output neighbor_input_value, neighbor_input_row, neighbor_input_column,
    output neighbor_input_write_enable, neighbor_exchange_done,
    input neighbor_cts, buffer_row_write, buffer_column_write, buffer_data_write, buffer_write_enable
  );
  modport slave (
    input neighbor_input_value, neighbor_input_row, neighbor_input_column,
    input neighbor_input_write_enable, neighbor_exchange_done,
    output neighbor_cts, buffer_row_write, buffer_column_write, buffer_data_write, buffer_write_enable
  );
endinterface

// File: rtl/halo_fifo.sv
// halo_fifo: synchronous FIFO of halo entries with occupancy output
// Ports: clk, rst (sync active-high flush), push/din, pop/dout (first-word fall-through), count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module halo_fifo
  import halo_receiver_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  halo_entry_t din,
  output halo_entry_t dout,
  output logic [AW:0] count
);
  halo_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/halo_receiver.sv
// halo_receiver: collects halo entries from neighbor links into per-link FIFOs and drains them round-robin into the tile buffer
// Ports: clk, reset_n (sync active-low), exchange_start / cycle_done (window open/close pulses),
//        link (halo_receiver_if.slave: neighbor entries, cts, buffer write port),
//        exchange_done (window complete and drained), overflow_error (sticky lost entry).
// Optional HALO_RX_STATS_EN adds rx_entry_count, a saturating count of buffer writes since exchange_start.
module halo_receiver
  import halo_receiver_pkg::*;
#(
  parameter int TILE_SIZE = 128,
  parameter int NEIGHBOR_COUNT = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(TILE_SIZE),
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int PW = NEIGHBOR_COUNT > 1 ? $clog2(NEIGHBOR_COUNT) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic exchange_start,
  input  logic cycle_done,
  halo_receiver_if.slave link,
  output logic exchange_done,
  output logic overflow_error
`ifdef HALO_RX_STATS_EN
  ,
  output logic [15:0] rx_entry_count
`endif
);
  halo_state_t state, state_nxt;
  halo_entry_t fifo_out [NEIGHBOR_COUNT];
  logic [AW:0] cnt [NEIGHBOR_COUNT];
  logic [NEIGHBOR_COUNT-1:0] push, pop, lost, busy, cts_nxt;
  logic [PW-1:0] ptr, grant;
  logic active, any_pop, flush;
  assign active = state == RECEIVE || state == DRAIN;
  assign flush = !reset_n || cycle_done;
  // Scan from the far end so the link closest to ptr wins; nothing drains on the closing edge.
  always_comb begin
    grant = ptr;
    any_pop = 1'b0;
    for (int i = NEIGHBOR_COUNT - 1; i >= 0; i--)
      if (cnt[(int'(ptr) + i) % NEIGHBOR_COUNT] != '0) begin
        grant = PW'((int'(ptr) + i) % NEIGHBOR_COUNT);
        any_pop = 1'b1;
      end
    any_pop = any_pop && !cycle_done;
  end
  for (genvar n = 0; n < NEIGHBOR_COUNT; n++) begin : g_link
    halo_entry_t din;
    logic [AW:0] cnt_nxt;
    assign din = {link.neighbor_input_value[n], HALO_CW_MAX'(link.neighbor_input_row[n]),
                  HALO_CW_MAX'(link.neighbor_input_column[n])};
    assign pop[n] = any_pop && grant == PW'(n);
    assign push[n] = link.neighbor_input_write_enable[n] && active && !cycle_done &&
                     (cnt[n] != (AW+1)'(FIFO_DEPTH) || pop[n]);
    assign lost[n] = link.neighbor_input_write_enable[n] && !cycle_done && !push[n];
    assign busy[n] = cnt[n] != '0;
    assign cnt_nxt = cnt[n] + (AW+1)'(push[n]) - (AW+1)'(pop[n]);
    // One free slot is kept so a write already in flight when cts falls still fits.
    assign cts_nxt[n] = state_nxt == RECEIVE && cnt_nxt <= (AW+1)'(FIFO_DEPTH - 2);
    halo_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(flush),
      .push(push[n]),
      .pop(pop[n]),
      .din(din),
      .dout(fifo_out[n]),
      .count(cnt[n])
    );
  end
  assign state_nxt = cycle_done ? IDLE
                   : (state == IDLE && exchange_start) ? RECEIVE
                   : (state == RECEIVE && &link.neighbor_exchange_done) ? DRAIN
                   : (state == DRAIN && busy == '0 && push == '0) ? DONE
                   : state;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      link.neighbor_cts <= '0;
      link.buffer_write_enable <= 1'b0;
      link.buffer_row_write <= '0;
      link.buffer_column_write <= '0;
      link.buffer_data_write <= '0;
      exchange_done <= 1'b0;
      overflow_error <= 1'b0;
    end else begin
      state <= state_nxt;
      link.neighbor_cts <= cts_nxt;
      exchange_done <= state_nxt == DONE;
      overflow_error <= overflow_error || |lost;
      link.buffer_write_enable <= any_pop;
      if (any_pop) begin
        ptr <= grant == PW'(NEIGHBOR_COUNT - 1) ? '0 : grant + 1'b1;
        link.buffer_row_write <= fifo_out[grant].row[CW-1:0];
        link.buffer_column_write <= fifo_out[grant].column[CW-1:0];
        link.buffer_data_write <= fifo_out[grant].value;
      end
    end
  end
`ifdef HALO_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n || exchange_start) rx_entry_count <= '0;
    else if (any_pop && rx_entry_count != 16'hFFFF) rx_entry_count <= rx_entry_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_halo_receiver.sv
// tb_halo_receiver: directed checks of the halo receiver window, FIFOs, arbiter and error flag
module tb_halo_receiver;
  logic clk = 1'b0;
  logic reset_n, exchange_start, cycle_done, exchange_done, overflow_error;
`ifdef HALO_RX_STATS_EN
  logic [15:0] rx_entry_count;
`endif
  int n_checks = 0, n_fail = 0;
  logic [21:0] wr_log [$];
  halo_receiver_if #(.TILE_SIZE(128), .NEIGHBOR_COUNT(8)) bus ();
  halo_receiver #(.TILE_SIZE(128), .NEIGHBOR_COUNT(8), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .exchange_start(exchange_start),
    .cycle_done(cycle_done),
    .link(bus),
    .exchange_done(exchange_done),
    .overflow_error(overflow_error)
`ifdef HALO_RX_STATS_EN
    ,
    .rx_entry_count(rx_entry_count)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bus.buffer_write_enable === 1'b1)
      wr_log.push_back({bus.buffer_row_write, bus.buffer_column_write, bus.buffer_data_write});
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic idle_links();
    for (int n = 0; n < 8; n++) begin
      bus.neighbor_input_value[n] = '0;
      bus.neighbor_input_row[n] = '0;
      bus.neighbor_input_column[n] = '0;
    end
    bus.neighbor_input_write_enable = '0;
    bus.neighbor_exchange_done = '0;
  endtask
  task automatic set_entry(input int n, input logic [7:0] v, input logic [6:0] r, input logic [6:0] c);
    bus.neighbor_input_value[n] = v;
    bus.neighbor_input_row[n] = r;
    bus.neighbor_input_column[n] = c;
    bus.neighbor_input_write_enable[n] = 1'b1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    exchange_start = 1'b0;
    cycle_done = 1'b0;
    idle_links();
    tick(2);
    reset_n = 1'b1;
    wr_log.delete();
  endtask
  task automatic start_window();
    exchange_start = 1'b1;
    tick();
    exchange_start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (exchange_done !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    check(tag, 32'(exchange_done), 1);
  endtask
  initial begin
    do_reset();
    check("rst_cts", 32'(bus.neighbor_cts), 0);
    check("rst_bwe", 32'(bus.buffer_write_enable), 0);
    check("rst_row", 32'(bus.buffer_row_write), 0);
    check("rst_col", 32'(bus.buffer_column_write), 0);
    check("rst_data", 32'(bus.buffer_data_write), 0);
    check("rst_done", 32'(exchange_done), 0);
    check("rst_ovf", 32'(overflow_error), 0);
    // single entry on link 3 arriving together with all exchange_done
    start_window();
    check("t33_cts_open", 32'(bus.neighbor_cts), 32'hFF);
    set_entry(3, 8'h5A, 7'd7, 7'd9);
    bus.neighbor_exchange_done = '1;
    tick();
    bus.neighbor_input_write_enable = '0;
    check("t33_no_early_we", 32'(bus.buffer_write_enable), 0);
    check("t33_cts_closed", 32'(bus.neighbor_cts), 0);
    tick();
    check("t33_we", 32'(bus.buffer_write_enable), 1);
    check("t33_entry", 32'({bus.buffer_row_write, bus.buffer_column_write, bus.buffer_data_write}),
          32'({7'd7, 7'd9, 8'h5A}));
    check("t33_done_low", 32'(exchange_done), 0);
    tick();
    check("t33_done", 32'(exchange_done), 1);
    check("t33_we_off", 32'(bus.buffer_write_enable), 0);
    start_window();
    check("t33_start_ignored", 32'(exchange_done), 1);
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    check("t33_done_cleared", 32'(exchange_done), 0);
    check("t33_writes", wr_log.size(), 1);
    check("t33_ovf", 32'(overflow_error), 0);
    // all links write every cycle for four cycles
    do_reset();
    start_window();
    for (int c = 0; c < 4; c++) begin
      for (int n = 0; n < 8; n++) set_entry(n, 8'(n * 16 + c), 7'(n), 7'(c));
      tick();
      if (c == 0) check("t34_cts_first", 32'(bus.neighbor_cts), 32'hFF);
    end
    bus.neighbor_input_write_enable = '0;
    check("t34_cts_dropped", 32'(bus.neighbor_cts), 0);
    bus.neighbor_exchange_done = '1;
    wait_done("t34_done_timeout", 60);
    check("t34_count", wr_log.size(), 32);
    for (int j = 0; j < 32 && j < wr_log.size(); j++)
      check($sformatf("t34_w%0d", j), 32'(wr_log[j]), 32'({7'(j % 8), 7'(j / 8), 8'((j % 8) * 16 + j / 8)}));
    check("t34_ovf", 32'(overflow_error), 0);
    // link 0 bursts five entries while the arbiter serves links 1..7
    do_reset();
    start_window();
    for (int n = 1; n < 8; n++) set_entry(n, 8'(8'h10 + n), 7'(n), 7'd0);
    tick();
    bus.neighbor_input_write_enable = '0;
    for (int k = 0; k < 5; k++) begin
      set_entry(0, 8'(8'hA0 + k), 7'd0, 7'(k));
      if (k == 4) check("t35_ovf_before", 32'(overflow_error), 0);
      tick();
      if (k == 1) check("t35_cts0_high", 32'(bus.neighbor_cts[0]), 1);
      if (k == 2) check("t35_cts0_low", 32'(bus.neighbor_cts[0]), 0);
    end
    bus.neighbor_input_write_enable = '0;
    check("t35_ovf", 32'(overflow_error), 1);
    bus.neighbor_exchange_done = '1;
    wait_done("t35_done_timeout", 40);
    check("t35_count", wr_log.size(), 11);
    for (int j = 0; j < 11 && j < wr_log.size(); j++)
      check($sformatf("t35_w%0d", j), 32'(wr_log[j]),
            j < 7 ? 32'({7'(j + 1), 7'd0, 8'(8'h11 + j)}) : 32'({7'd0, 7'(j - 7), 8'(8'hA0 + j - 7)}));
    // write while idle
    do_reset();
    set_entry(2, 8'h33, 7'd1, 7'd1);
    tick();
    bus.neighbor_input_write_enable = '0;
    tick(4);
    check("t36_writes", wr_log.size(), 0);
    check("t36_ovf", 32'(overflow_error), 1);
    check("t36_done", 32'(exchange_done), 0);
    // cycle_done while three entries wait in DRAIN
    do_reset();
    start_window();
    for (int n = 0; n < 3; n++) set_entry(n, 8'(8'hC0 + n), 7'(n), 7'(n));
    bus.neighbor_exchange_done = '1;
    tick();
    bus.neighbor_input_write_enable = '0;
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    tick(5);
    check("t37_writes", wr_log.size(), 0);
    check("t37_cts", 32'(bus.neighbor_cts), 0);
    check("t37_done", 32'(exchange_done), 0);
    start_window();
    tick(2);
    check("t37_flushed_done", 32'(exchange_done), 1);
    check("t37_flushed_writes", wr_log.size(), 0);
    exchange_start = 1'b1;
    cycle_done = 1'b1;
    tick();
    exchange_start = 1'b0;
    cycle_done = 1'b0;
    check("t37_cd_beats_start", 32'(bus.neighbor_cts), 0);
    check("t37_ovf", 32'(overflow_error), 0);
`ifdef HALO_RX_STATS_EN
    do_reset();
    start_window();
    for (int c = 0; c < 2; c++) begin
      for (int n = 0; n < 5; n++) set_entry(n, 8'(c * 8 + n), 7'(n), 7'(c));
      tick();
    end
    bus.neighbor_input_write_enable = '0;
    bus.neighbor_exchange_done = '1;
    wait_done("t38_done_timeout", 40);
    check("t38_count", 32'(rx_entry_count), 10);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/halo_receiver.md
HALO_RECEIVER -- requirements
Module: halo_receiver

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 128, tile edge length; row/column width CW = $clog2(TILE_SIZE).
REQ-002 SHALL have parameter NEIGHBOR_COUNT, default 8, number of neighbor links.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per neighbor FIFO (power of two, >=4).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 exchange_start  input  1  one-cycle pulse opening a receive window.
REQ-007 cycle_done  input  1  one-cycle pulse closing the window and flushing state.
REQ-008 neighbor_input_value[NEIGHBOR_COUNT]  input  8 each  received activation.
REQ-009 neighbor_input_row[NEIGHBOR_COUNT], neighbor_input_column[NEIGHBOR_COUNT]  input  CW each  target coordinate.
REQ-010 neighbor_input_write_enable[NEIGHBOR_COUNT]  input  1 each  entry valid this cycle.
REQ-011 neighbor_exchange_done[NEIGHBOR_COUNT]  input  1 each  level; neighbor has sent its last entry.
REQ-012 neighbor_cts[NEIGHBOR_COUNT]  output  1 each  registered clear-to-send per link.
REQ-013 buffer_row_write, buffer_column_write  output  CW  write coordinate; buffer_data_write  output  8  write data; buffer_write_enable  output  1  write strobe.
REQ-014 exchange_done  output  1  receive window complete and drained.
REQ-015 overflow_error  output  1  sticky: entry lost (full FIFO or write outside RECEIVE).

Function
REQ-016 SHALL implement states IDLE, RECEIVE, DRAIN, DONE.
REQ-017 IDLE->RECEIVE on exchange_start; exchange_start in any other state ignored.
REQ-018 RECEIVE->DRAIN when all neighbor_exchange_done sampled high (same cycle as entry acceptance allowed; that entry kept).
REQ-019 DRAIN->DONE when all FIFOs empty and no write issued that cycle; exchange_done high exactly while in DONE.
REQ-020 any state->IDLE on cycle_done; FIFOs flushed same edge; cycle_done beats exchange_start when simultaneous.
REQ-021 In RECEIVE/DRAIN each asserted write_enable pushes {value,row,column} into its link FIFO regardless of cts, unless FIFO full: then dropped, overflow_error set.
REQ-022 write_enable in IDLE or DONE SHALL be dropped and set overflow_error.
REQ-023 neighbor_cts[n] registered high iff state is RECEIVE and FIFO n occupancy after this edge <= FIFO_DEPTH-2 (one in-flight write absorbed).
REQ-024 Round-robin arbiter SHALL pop at most one non-empty FIFO per cycle, priority starting one past last granted link; pointer resets to link 0.
REQ-025 Output registers SHALL load popped entry; entry accepted at edge k appears on buffer_* with buffer_write_enable high after edge k+1 at earliest.
REQ-026 Simultaneous push and pop on one FIFO SHALL keep occupancy unchanged; full FIFO with a pop that cycle accepts the push.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; entries leave each link in arrival order.

Reset
REQ-028 On reset_n low at clock edge: state IDLE, FIFOs empty, arbiter pointer 0, neighbor_cts all 0, buffer_write_enable 0, buffer_row/column/data_write 0, exchange_done 0, overflow_error 0.
REQ-029 Reset mid-window SHALL discard all buffered entries with no further writes.

Configuration
REQ-030 Macro HALO_RX_STATS_EN defined: output rx_entry_count (16 bits) counts entries written to buffer since exchange_start, saturates at 16'hFFFF, clears on exchange_start and reset. Undefined: port and counter absent, otherwise identical behaviour.

Structure
REQ-031 Shared package SHALL hold halo entry struct {value[7:0], row, column} and state enum.
REQ-032 One sub-module halo_fifo (parameterised sync FIFO with occupancy output), instantiated NEIGHBOR_COUNT times.

Verification
REQ-033 Reset, start, link 3 sends (val 8'h5A,row 7,col 9), all done high -> buffer write (7,9,8'h5A) two cycles after send, exchange_done next cycle.
REQ-034 All 8 links write every cycle for 4 cycles -> 32 writes in round-robin order 0..7, no overflow, cts drops on each link.
REQ-035 Link 0 writes 5 back-to-back, ignoring cts, arbiter busy elsewhere -> fifth dropped only if FIFO full at push; overflow_error=1.
REQ-036 Write in IDLE -> no buffer write, overflow_error=1.
REQ-037 cycle_done mid-DRAIN with 3 entries queued -> IDLE next cycle, zero further buffer writes.
REQ-038 HALO_RX_STATS_EN: 10 entries received -> rx_entry_count=10 after drain.
